// File: rtl/midi_note_serializer.sv
// -----------------------------------------------------------------------------
// midi_note_serializer
//
// Encodes note events into 3-byte MIDI Note On/Off messages, buffers them in a
// small message FIFO and serializes them as a byte stream.  Optional running
// status drops a status byte that repeats the previously transmitted one.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   in_valid    note event valid
//   in_ready    FIFO can accept an event (registered level only)
//   note_on     1 = Note On (0x9n), 0 = Note Off (0x8n)
//   note        semitone within octave (0..15 accepted as-is)
//   octave      octave index
//   channel     MIDI channel
//   velocity    velocity byte for both on and off
//   rs_clear    forget running status
//   out_data    serialized MIDI byte (registered)
//   out_valid   out_data valid (registered)
//   out_ready   downstream accepts byte
//   fifo_level  messages buffered
//   busy        serializer active or messages pending
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | nothing on the output; pops the FIFO head when non-empty
// STATUS  | status byte on out_data, waiting for out_ready
// DATA1   | note byte on out_data, waiting for out_ready
// DATA2   | velocity byte on out_data; on accept chains the next message
// -----------------------------------------------------------------------------
module midi_note_serializer #(
    parameter int         DEPTH          = 4,
    parameter int         OCT_W          = 2,
    parameter logic [6:0] MIDI_NOTE_BASE = 7'h00,
    parameter int         RUNNING_STATUS = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     note_on,
    input  logic [3:0]               note,
    input  logic [OCT_W-1:0]         octave,
    input  logic [3:0]               channel,
    input  logic [6:0]               velocity,
    input  logic                     rs_clear,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam bit RS_EN = (RUNNING_STATUS != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STATUS,
        S_DATA1,
        S_DATA2
    } state_t;

    state_t state;

    // -------------------------------------------------------------------------
    // Event encoding
    // -------------------------------------------------------------------------
    logic [11:0] note_sum;
    logic [7:0]  enc_status;
    logic [7:0]  enc_note;
    logic [23:0] enc_msg;

    // 12 bits is enough for any octave*12 + 15 + 127 at the widths used here,
    // so the saturation compare never sees a wrapped value.
    assign note_sum   = 12'(octave) * 12'd12 + 12'(note) + 12'(MIDI_NOTE_BASE);
    assign enc_note   = (note_sum > 12'd127) ? 8'h7F : {1'b0, note_sum[6:0]};
    assign enc_status = {(note_on ? 4'h9 : 4'h8), channel};
    assign enc_msg    = {enc_status, enc_note, 1'b0, velocity};

    // -------------------------------------------------------------------------
    // Message FIFO
    // -------------------------------------------------------------------------
    logic [23:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic          level_nz;

    logic [7:0]    head_status;
    logic [7:0]    head_note;
    logic [7:0]    head_vel;

    assign level_nz = (fifo_level != '0);
    assign in_ready = (fifo_level != FULL_LEVEL);
    assign push     = in_valid && in_ready;
    // Pop whenever the FSM is about to load a new first byte: from IDLE, or
    // back-to-back after the velocity byte is taken.
    assign pop      = level_nz &&
                      ((state == S_IDLE) || ((state == S_DATA2) && out_ready));

    assign head_status = mem[rd_ptr][23:16];
    assign head_note   = mem[rd_ptr][15:8];
    assign head_vel    = mem[rd_ptr][7:0];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc_msg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Serializer FSM
    // -------------------------------------------------------------------------
    logic [7:0] cur_status;
    logic [7:0] cur_note;
    logic [7:0] cur_vel;
    logic [7:0] last_status;
    logic       rs_valid;
    logic       skip_status;
    logic [7:0] first_byte;
    state_t     first_state;

    // Skip decision uses the registered rs_valid, so an rs_clear sampled on
    // the same edge as a pop only affects later pops.
    assign skip_status = RS_EN && rs_valid && (head_status == last_status);
    assign first_byte  = skip_status ? head_note : head_status;
    assign first_state = skip_status ? S_DATA1 : S_STATUS;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            out_valid   <= 1'b0;
            out_data    <= 8'h00;
            cur_status  <= 8'h00;
            cur_note    <= 8'h00;
            cur_vel     <= 8'h00;
            last_status <= 8'h00;
            rs_valid    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        cur_status <= head_status;
                        cur_note   <= head_note;
                        cur_vel    <= head_vel;
                        out_data   <= first_byte;
                        out_valid  <= 1'b1;
                        state      <= first_state;
                    end
                end
                S_STATUS: begin
                    if (out_ready) begin
                        out_data    <= cur_note;
                        last_status <= cur_status;
                        rs_valid    <= RS_EN;
                        state       <= S_DATA1;
                    end
                end
                S_DATA1: begin
                    if (out_ready) begin
                        out_data <= cur_vel;
                        state    <= S_DATA2;
                    end
                end
                S_DATA2: begin
                    if (out_ready) begin
                        if (pop) begin
                            cur_status <= head_status;
                            cur_note   <= head_note;
                            cur_vel    <= head_vel;
                            out_data   <= first_byte;
                            state      <= first_state;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase

            // Placed last so it overrides the set on STATUS->DATA1.
            if (rs_clear) begin
                rs_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != S_IDLE) || level_nz;

endmodule

// File: tb/tb_midi_note_serializer.sv
// -----------------------------------------------------------------------------
// Directed bench for midi_note_serializer.  Three instances share one input
// stimulus:
//   a : base 0x24, running status on
//   b : base 0x24, running status off
//   c : base 0x60, running status on (exercises note saturation)
// Each instance's accepted output bytes are collected and compared against
// hand-computed byte sequences.
// -----------------------------------------------------------------------------
module tb_midi_note_serializer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       note_on;
    logic [3:0] note;
    logic [1:0] octave;
    logic [3:0] channel;
    logic [6:0] velocity;
    logic       rs_clear;
    logic       out_ready;

    logic       in_ready_a, in_ready_b, in_ready_c;
    logic [7:0] out_data_a, out_data_b, out_data_c;
    logic       out_valid_a, out_valid_b, out_valid_c;
    logic [2:0] fifo_level_a, fifo_level_b, fifo_level_c;
    logic       busy_a, busy_b, busy_c;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];
    logic [7:0] q_c[$];
    logic [7:0] e_a[$];
    logic [7:0] e_b[$];
    logic [7:0] e_c[$];

    always #5 clk = ~clk;

    midi_note_serializer #(.DEPTH(4), .OCT_W(2), .MIDI_NOTE_BASE(7'h24), .RUNNING_STATUS(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .note_on(note_on), .note(note), .octave(octave), .channel(channel),
        .velocity(velocity), .rs_clear(rs_clear), .out_data(out_data_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .fifo_level(fifo_level_a),
        .busy(busy_a)
    );

    midi_note_serializer #(.DEPTH(4), .OCT_W(2), .MIDI_NOTE_BASE(7'h24), .RUNNING_STATUS(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .note_on(note_on), .note(note), .octave(octave), .channel(channel),
        .velocity(velocity), .rs_clear(rs_clear), .out_data(out_data_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .fifo_level(fifo_level_b),
        .busy(busy_b)
    );

    midi_note_serializer #(.DEPTH(4), .OCT_W(2), .MIDI_NOTE_BASE(7'h60), .RUNNING_STATUS(1)) dut_c (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .note_on(note_on), .note(note), .octave(octave), .channel(channel),
        .velocity(velocity), .rs_clear(rs_clear), .out_data(out_data_c),
        .out_valid(out_valid_c), .out_ready(out_ready), .fifo_level(fifo_level_c),
        .busy(busy_c)
    );

    // Byte transfers happen at the next rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (reset_n && out_ready) begin
            if (out_valid_a) q_a.push_back(out_data_a);
            if (out_valid_b) q_b.push_back(out_data_b);
            if (out_valid_c) q_c.push_back(out_data_c);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_stream(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++) begin
            if (i < got.size()) begin
                check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp[i]));
            end
        end
    endtask

    task automatic clear_queues();
        q_a.delete();
        q_b.delete();
        q_c.delete();
    endtask

    task automatic set_event(input logic on, input logic [3:0] ch, input logic [1:0] oct,
                             input logic [3:0] nt, input logic [6:0] vel);
        note_on  = on;
        channel  = ch;
        octave   = oct;
        note     = nt;
        velocity = vel;
    endtask

    task automatic push_ev(input logic on, input logic [3:0] ch, input logic [1:0] oct,
                           input logic [3:0] nt, input logic [6:0] vel);
        int n;
        n = 0;
        while (!(in_ready_a && in_ready_b && in_ready_c) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) begin
            total_cnt++;
            $error("FAIL push_timeout observed=in_ready_low expected=in_ready_high");
        end
        set_event(on, ch, oct, nt, vel);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy_a || busy_b || busy_c) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total_cnt++;
            $error("FAIL idle_timeout observed=busy expected=idle");
        end
    endtask

    initial begin
        logic       no_bubble;
        logic [2:0] exp_lvl[6];

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        rs_clear  = 1'b0;
        out_ready = 1'b1;
        set_event(1'b0, 4'h0, 2'd0, 4'h0, 7'h00);

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid_a), 32'd0);
        check("rst_out_data", 32'(out_data_a), 32'h00);
        check("rst_level", 32'(fifo_level_a), 32'd0);
        check("rst_in_ready", 32'(in_ready_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single Note On, latency and consecutive bytes
        clear_queues();
        set_event(1'b1, 4'h3, 2'd2, 4'h4, 7'h64);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("p1_valid_after_accept", 32'(out_valid_a), 32'd0);
        check("p1_level_after_accept", 32'(fifo_level_a), 32'd1);
        @(posedge clk);
        #1;
        check("p1_first_valid", 32'(out_valid_a), 32'd1);
        check("p1_first_byte", 32'(out_data_a), 32'h93);
        @(posedge clk);
        #1;
        check("p1_second_byte", 32'(out_data_a), 32'h40);
        @(posedge clk);
        #1;
        check("p1_third_byte", 32'(out_data_a), 32'h64);
        @(posedge clk);
        #1;
        check("p1_valid_end", 32'(out_valid_a), 32'd0);
        wait_idle();
        e_a = '{8'h93, 8'h40, 8'h64};
        e_b = '{8'h93, 8'h40, 8'h64};
        e_c = '{8'h93, 8'h7C, 8'h64};
        check_stream("p1_a", q_a, e_a);
        check_stream("p1_b", q_b, e_b);
        check_stream("p1_c", q_c, e_c);

        // 2: running status after a fresh reset
        reset_n = 1'b0;
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        clear_queues();
        push_ev(1'b1, 4'h3, 2'd2, 4'h4, 7'h64);
        push_ev(1'b1, 4'h3, 2'd2, 4'h4, 7'h64);
        push_ev(1'b0, 4'h3, 2'd2, 4'h4, 7'h64);
        wait_idle();
        e_a = '{8'h93, 8'h40, 8'h64, 8'h40, 8'h64, 8'h83, 8'h40, 8'h64};
        e_b = '{8'h93, 8'h40, 8'h64, 8'h93, 8'h40, 8'h64, 8'h83, 8'h40, 8'h64};
        e_c = '{8'h93, 8'h7C, 8'h64, 8'h7C, 8'h64, 8'h83, 8'h7C, 8'h64};
        check_stream("p2_a", q_a, e_a);
        check_stream("p2_b", q_b, e_b);
        check_stream("p2_c", q_c, e_c);

        // 3: saturation (a/b: 87 -> 0x57, c: 147 -> 0x7F)
        clear_queues();
        push_ev(1'b1, 4'h0, 2'd3, 4'hF, 7'h10);
        wait_idle();
        e_a = '{8'h90, 8'h57, 8'h10};
        e_b = '{8'h90, 8'h57, 8'h10};
        e_c = '{8'h90, 8'h7F, 8'h10};
        check_stream("p3_a", q_a, e_a);
        check_stream("p3_b", q_b, e_b);
        check_stream("p3_c", q_c, e_c);

        // 4: backpressure and full FIFO
        clear_queues();
        out_ready  = 1'b0;
        exp_lvl[0] = 3'd1;
        exp_lvl[1] = 3'd1;
        exp_lvl[2] = 3'd2;
        exp_lvl[3] = 3'd3;
        exp_lvl[4] = 3'd4;
        exp_lvl[5] = 3'd4;
        for (int i = 0; i < 6; i++) begin
            set_event(1'b1, 4'(i + 1), 2'd1, 4'(i), 7'(8'h20 + i));
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("p4_level%0d", i), 32'(fifo_level_a), 32'(exp_lvl[i]));
        end
        check("p4_in_ready_full", 32'(in_ready_a), 32'd0);
        check("p4_level_c_full", 32'(fifo_level_c), 32'd4);
        check("p4_held_valid", 32'(out_valid_a), 32'd1);
        check("p4_held_data", 32'(out_data_a), 32'h91);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("p4_held_data_later", 32'(out_data_a), 32'h91);
        check("p4_held_level_later", 32'(fifo_level_a), 32'd4);
        check("p4_in_ready_still_low", 32'(in_ready_b), 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        no_bubble = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            no_bubble = no_bubble & out_valid_a & out_valid_b & out_valid_c;
        end
        check("p4_no_bubble", 32'(no_bubble), 32'd1);
        wait_idle();
        e_a.delete();
        e_c.delete();
        for (int i = 0; i < 5; i++) begin
            e_a.push_back(8'(8'h91 + i));
            e_a.push_back(8'(8'h30 + i));
            e_a.push_back(8'(8'h20 + i));
            e_c.push_back(8'(8'h91 + i));
            e_c.push_back(8'(8'h6C + i));
            e_c.push_back(8'(8'h20 + i));
        end
        e_b = e_a;
        check_stream("p4_a", q_a, e_a);
        check_stream("p4_b", q_b, e_b);
        check_stream("p4_c", q_c, e_c);

        // 5: rs_clear between identical events, then a repeat without clear
        clear_queues();
        push_ev(1'b1, 4'h3, 2'd2, 4'h4, 7'h64);
        wait_idle();
        rs_clear = 1'b1;
        @(posedge clk);
        #1;
        rs_clear = 1'b0;
        push_ev(1'b1, 4'h3, 2'd2, 4'h4, 7'h64);
        wait_idle();
        push_ev(1'b1, 4'h3, 2'd2, 4'h4, 7'h64);
        wait_idle();
        e_a = '{8'h93, 8'h40, 8'h64, 8'h93, 8'h40, 8'h64, 8'h40, 8'h64};
        e_b = '{8'h93, 8'h40, 8'h64, 8'h93, 8'h40, 8'h64, 8'h93, 8'h40, 8'h64};
        e_c = '{8'h93, 8'h7C, 8'h64, 8'h93, 8'h7C, 8'h64, 8'h7C, 8'h64};
        check_stream("p5_a", q_a, e_a);
        check_stream("p5_b", q_b, e_b);
        check_stream("p5_c", q_c, e_c);

        // 6: asynchronous reset while in DATA1
        out_ready = 1'b0;
        set_event(1'b0, 4'h1, 2'd0, 4'h0, 7'h11);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("p6_data1_byte", 32'(out_data_a), 32'h24);
        check("p6_data1_level", 32'(fifo_level_a), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("p6_async_valid", 32'(out_valid_a), 32'd0);
        check("p6_async_level", 32'(fifo_level_a), 32'd0);
        check("p6_async_data", 32'(out_data_c), 32'h00);
        check("p6_async_busy", 32'(busy_b), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        clear_queues();
        out_ready = 1'b1;
        push_ev(1'b0, 4'h1, 2'd0, 4'h0, 7'h11);
        wait_idle();
        e_a = '{8'h81, 8'h24, 8'h11};
        e_b = '{8'h81, 8'h24, 8'h11};
        e_c = '{8'h81, 8'h60, 8'h11};
        check_stream("p6_a", q_a, e_a);
        check_stream("p6_b", q_b, e_b);
        check_stream("p6_c", q_c, e_c);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
